// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the CPU-side memory access controller:
//   ADDR_W_DEFAULT  default RAM word-address width
//   SZ_*            encodings of the 2-bit access size field
//   state_t         controller FSM states
//   isBadAccess     flags accesses rejected without touching the RAM
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int ADDR_W_DEFAULT = 10;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    CAPT = 2'b10,
    WR   = 2'b11
  } state_t;

  // An access is rejected when its size code is illegal or when the byte
  // offset is not a multiple of the access size.
  function automatic logic isBadAccess(input logic [1:0] size,
                                       input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// ---------------------------------------------------------------------------
// byte_lane_unit
// Purely combinational lane steering for big-endian byte/half/word accesses.
// Ports:
//   i_ramWord     word read from the RAM
//   i_storeData   store data, right-aligned for byte/half
//   i_size        access size code (SZ_*)
//   i_offset      byte offset inside the word
//   i_uns         1 = zero-extend loads, 0 = sign-extend
//   o_loadData    selected lane, extended to 32 bits
//   o_mergedWord  i_ramWord with the addressed lane replaced by store data
// Offset 0 is the most significant byte, offset 3 the least significant.
// ---------------------------------------------------------------------------
module byte_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] i_ramWord,
  input  logic [31:0] i_storeData,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_uns,
  output logic [31:0] o_loadData,
  output logic [31:0] o_mergedWord
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection: pick the addressed byte and half out of the RAM word.
  always_comb begin
    w_byte = 8'h00;
    case (i_offset)
      2'd0: w_byte = i_ramWord[31:24];
      2'd1: w_byte = i_ramWord[23:16];
      2'd2: w_byte = i_ramWord[15:8];
      default: w_byte = i_ramWord[7:0];
    endcase
    w_half = i_offset[1] ? i_ramWord[15:0] : i_ramWord[31:16];
  end

  // Load extension and store merge. Word-sized accesses pass straight
  // through; the merge result for a word is simply the store data.
  always_comb begin
    o_loadData   = i_ramWord;
    o_mergedWord = i_ramWord;
    case (i_size)
      SZ_BYTE: begin
        o_loadData = {{24{~i_uns & w_byte[7]}}, w_byte};
        case (i_offset)
          2'd0: o_mergedWord[31:24] = i_storeData[7:0];
          2'd1: o_mergedWord[23:16] = i_storeData[7:0];
          2'd2: o_mergedWord[15:8]  = i_storeData[7:0];
          default: o_mergedWord[7:0] = i_storeData[7:0];
        endcase
      end
      SZ_HALF: begin
        o_loadData = {{16{~i_uns & w_half[15]}}, w_half};
        if (i_offset[1]) begin
          o_mergedWord[15:0] = i_storeData[15:0];
        end else begin
          o_mergedWord[31:16] = i_storeData[15:0];
        end
      end
      default: begin
        o_loadData   = i_ramWord;
        o_mergedWord = i_storeData;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Bridges a simple CPU load/store request interface onto a single-port
// synchronous RAM (writes on ram_we, otherwise registers ram_dout).
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   req             access request, taken only while ready=1
//   wr              1 = store, 0 = load
//   size            SZ_BYTE / SZ_HALF / SZ_WORD (11 is illegal)
//   uns             zero-extend (1) or sign-extend (0) loads
//   baddr           byte address (ADDR_W+2 bits)
//   wdata           store data, right-aligned for byte/half
//   ready           high while the controller is IDLE
//   done, err       one-cycle completion pulse and its error flag
//   rdata           last load result, held between loads
//   ram_we/ram_addr/ram_din/ram_dout  RAM port
// Sub-word stores are read-modify-write: RD -> CAPT (merge) -> WR.
// ---------------------------------------------------------------------------
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W+1:0] baddr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_offset;
  logic [1:0]        r_size;
  logic              r_uns;
  logic              r_wr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_merged;
  logic [31:0]       r_rdata;
  logic              r_done;
  logic              r_err;
  logic              w_accept;
  logic              w_bad;
  logic [31:0]       w_loadData;
  logic [31:0]       w_mergedWord;

  byte_lane_unit u_laneUnit (
    .i_ramWord    (ram_dout),
    .i_storeData  (r_wdata),
    .i_size       (r_size),
    .i_offset     (r_offset),
    .i_uns        (r_uns),
    .o_loadData   (w_loadData),
    .o_mergedWord (w_mergedWord)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and FSM outputs. Rejected requests are answered from IDLE
  // without leaving it; a full-word store needs no read and goes straight
  // to WR.
  always_comb begin
    w_nextState = r_state;
    ready       = 1'b0;
    ram_we      = 1'b0;
    w_accept    = 1'b0;
    w_bad       = isBadAccess(size, baddr[1:0]);
    case (r_state)
      IDLE: begin
        ready    = 1'b1;
        w_accept = req;
        if (req && !w_bad) begin
          w_nextState = (wr && (size == SZ_WORD)) ? WR : RD;
        end
      end
      RD: begin
        w_nextState = CAPT;
      end
      CAPT: begin
        w_nextState = r_wr ? WR : IDLE;
      end
      WR: begin
        ram_we      = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers. The request fields are latched on acceptance so
  // the CPU may change its inputs once ready drops. done/err default low
  // so they pulse for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_offset <= 2'b00;
      r_size   <= SZ_BYTE;
      r_uns    <= 1'b0;
      r_wr     <= 1'b0;
      r_wdata  <= 32'h0;
      r_merged <= 32'h0;
      r_rdata  <= 32'h0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_accept) begin
        if (w_bad) begin
          r_done <= 1'b1;
          r_err  <= 1'b1;
        end else begin
          r_addr   <= baddr[ADDR_W+1:2];
          r_offset <= baddr[1:0];
          r_size   <= size;
          r_uns    <= uns;
          r_wr     <= wr;
          r_wdata  <= wdata;
          if (wr) begin
            r_merged <= wdata;
          end
        end
      end
      if (r_state == CAPT) begin
        if (r_wr) begin
          r_merged <= w_mergedWord;
        end else begin
          r_rdata <= w_loadData;
          r_done  <= 1'b1;
        end
      end
      if (r_state == WR) begin
        r_done <= 1'b1;
      end
    end
  end

  assign done     = r_done;
  assign err      = r_err;
  assign rdata    = r_rdata;
  assign ram_addr = r_addr;
  assign ram_din  = r_merged;

endmodule
